// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit saturating BHT, trained from EX resolution.
// Optional build macro BPU_GSHARE_EN adds a global history register XORed into the lookup index.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           if_pc,
    output logic                  if_pred_taken,
    output logic [31:0]           if_pred_target,
    output logic [INDEX_BITS-1:0] if_pred_index,
    input  logic                  ex_valid,
    input  logic [31:0]           ex_pc,
    input  logic [INDEX_BITS-1:0] ex_pred_index,
    input  logic                  ex_pred_taken,
    input  logic                  ex_branch_taken,
    input  logic [31:0]           ex_branch_target,
    input  logic                  stall,
    output logic [31:0]           perf_branches,
    output logic [31:0]           perf_mispredicts
);

    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned TAG_LSB  = INDEX_BITS + 2;
    localparam int unsigned TAG_END  = TAG_LSB + TAG_BITS;
    localparam int unsigned TGT_BITS = 30;

    logic [1:0]          bht        [ENTRIES];
    logic                btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [TGT_BITS-1:0] btb_target [ENTRIES];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic                  hit;
    logic                  update;
    logic [1:0]            bht_cur;
    logic [1:0]            bht_next;
    logic                  unused_bits;

    assign update     = ex_valid && !stall;
    assign lookup_tag = if_pc[TAG_LSB +: TAG_BITS];

`ifdef BPU_GSHARE_EN
    logic [INDEX_BITS-1:0] ghr;

    assign lookup_idx = if_pc[INDEX_BITS+1:2] ^ ghr;

    // History shifts in resolved outcomes only, never speculative predictions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (update) begin
            ghr <= {ghr[INDEX_BITS-2:0], ex_branch_taken};
        end
    end
`else
    assign lookup_idx = if_pc[INDEX_BITS+1:2];
`endif

    // Combinational lookup against registered tables; no write-to-read bypass
    always_comb begin
        hit            = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);
        if_pred_taken  = hit && bht[lookup_idx][1];
        if_pred_index  = lookup_idx;
        if_pred_target = if_pred_taken ? {btb_target[lookup_idx], 2'b00} : (if_pc + 32'd4);
    end

    always_comb begin
        bht_cur  = bht[ex_pred_index];
        bht_next = bht_cur;
        if (ex_branch_taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
        end
    end

    // Tables train at the index carried down the pipeline with the branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                bht[i]        <= 2'b01;
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
            end
        end else if (update) begin
            bht[ex_pred_index] <= bht_next;
            if (ex_branch_taken) begin
                btb_valid[ex_pred_index]  <= 1'b1;
                btb_tag[ex_pred_index]    <= ex_pc[TAG_LSB +: TAG_BITS];
                btb_target[ex_pred_index] <= ex_branch_target[31:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (update) begin
            if (perf_branches != 32'hFFFF_FFFF) perf_branches <= perf_branches + 32'd1;
            if ((ex_pred_taken != ex_branch_taken) && (perf_mispredicts != 32'hFFFF_FFFF))
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end

    assign unused_bits = ^{ex_pc[31:TAG_END], ex_pc[TAG_LSB-1:0], ex_branch_target[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table plus randomized traffic vs. a behavioural model.
module tb_branch_predictor;

    localparam int unsigned IB = 6;
    localparam int unsigned TB = 8;
    localparam int unsigned N  = 1 << IB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   if_pc;
    logic          if_pred_taken;
    logic [31:0]   if_pred_target;
    logic [IB-1:0] if_pred_index;
    logic          ex_valid;
    logic [31:0]   ex_pc;
    logic [IB-1:0] ex_pred_index;
    logic          ex_pred_taken;
    logic          ex_branch_taken;
    logic [31:0]   ex_branch_target;
    logic          stall;
    logic [31:0]   perf_branches;
    logic [31:0]   perf_mispredicts;

    branch_predictor #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .if_pred_taken    (if_pred_taken),
        .if_pred_target   (if_pred_target),
        .if_pred_index    (if_pred_index),
        .ex_valid         (ex_valid),
        .ex_pc            (ex_pc),
        .ex_pred_index    (ex_pred_index),
        .ex_pred_taken    (ex_pred_taken),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .stall            (stall),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain arrays and arithmetic
    int          m_ctr   [N];
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int unsigned m_ghr;
    longint      m_br;
    longint      m_mp;

    function automatic void model_reset();
        for (int i = 0; i < int'(N); i++) begin
            m_ctr[i] = 1; m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0;
        end
        m_ghr = 0; m_br = 0; m_mp = 0;
    endfunction

    function automatic int unsigned model_index(input int unsigned pc);
`ifdef BPU_GSHARE_EN
        return ((pc / 4) % N) ^ m_ghr;
`else
        return (pc / 4) % N;
`endif
    endfunction

    function automatic void model_predict(input int unsigned pc, output bit taken, output int unsigned tgt);
        int unsigned idx = model_index(pc);
        bit h = m_valid[idx] && (m_tag[idx] == ((pc / (4 * N)) % (1 << TB)));
        taken = h && (m_ctr[idx] >= 2);
        tgt   = taken ? m_tgt[idx] : pc + 32'd4;
    endfunction

    function automatic void model_train(input int unsigned idx, input int unsigned pc, input bit pt,
                                        input bit bt, input int unsigned tgt);
        if (bt) begin
            if (m_ctr[idx] < 3) m_ctr[idx]++;
            m_valid[idx] = 1;
            m_tag[idx]   = (pc / (4 * N)) % (1 << TB);
            m_tgt[idx]   = tgt & 32'hFFFF_FFFC;
        end else if (m_ctr[idx] > 0) begin
            m_ctr[idx]--;
        end
        m_ghr = ((m_ghr * 2) + (bt ? 1 : 0)) % N;
        if (m_br < 64'hFFFF_FFFF) m_br++;
        if (pt != bt && m_mp < 64'hFFFF_FFFF) m_mp++;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic v, input logic st, input logic [31:0] epc,
                         input logic [IB-1:0] eidx, input logic pt, input logic bt, input logic [31:0] etgt);
        if_pc = pc; ex_valid = v; stall = st; ex_pc = epc; ex_pred_index = eidx;
        ex_pred_taken = pt; ex_branch_taken = bt; ex_branch_target = etgt;
    endtask

    // Apply inputs at negedge, check lookup, then clock and check counters against the model
    task automatic model_cycle(input logic [31:0] pc, input logic v, input logic st, input logic [31:0] epc,
                               input logic [IB-1:0] eidx, input logic pt, input logic bt, input logic [31:0] etgt);
        bit          e_t;
        int unsigned e_tg;
        @(negedge clk);
        drive(pc, v, st, epc, eidx, pt, bt, etgt);
        #1;
        model_predict(pc, e_t, e_tg);
        chk("rand_taken", 32'(if_pred_taken), 32'(e_t));
        chk("rand_target", if_pred_target, e_tg);
        chk("rand_index", 32'(if_pred_index), model_index(pc));
        @(posedge clk);
        if (v && !st) model_train(32'(eidx), epc, pt, bt, etgt);
        #1;
        chk("rand_branches", perf_branches, 32'(m_br));
        chk("rand_mispredicts", perf_mispredicts, 32'(m_mp));
    endtask

    typedef struct {
        logic [31:0]   pc;
        logic          v;
        logic          st;
        logic [31:0]   epc;
        logic [IB-1:0] eidx;
        logic          pt;
        logic          bt;
        logic [31:0]   etgt;
        logic          exp_taken;
        logic [31:0]   exp_target;
        logic [31:0]   exp_br;
        logic [31:0]   exp_mp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        drive(32'h40, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        #2;
        chk("reset_taken", 32'(if_pred_taken), 32'd0);
        chk("reset_target", if_pred_target, 32'h44);
        chk("reset_index", 32'(if_pred_index), 32'h10);
        chk("reset_branches", perf_branches, 32'd0);
        chk("reset_mispredicts", perf_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifndef BPU_GSHARE_EN
        //          pc            v  st epc          idx pt bt etgt          taken target        br mp
        vecs.push_back('{32'h40,        0, 0, 32'h0,   0, 0, 0, 32'h0,       0, 32'h44,        0, 0});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 0, 1, 32'h200,     0, 32'h104,       1, 1});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 0, 1, 32'h200,     1, 32'h200,       2, 2});
        vecs.push_back('{32'h100,       0, 0, 32'h0,   0, 0, 0, 32'h0,       1, 32'h200,       2, 2});
        vecs.push_back('{32'h200,       0, 0, 32'h0,   0, 0, 0, 32'h0,       0, 32'h204,       2, 2});
        vecs.push_back('{32'h100,       1, 1, 32'h100, 0, 1, 0, 32'h0,       1, 32'h200,       2, 2});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 1, 0, 32'h0,       1, 32'h200,       3, 3});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 1, 0, 32'h0,       1, 32'h200,       4, 4});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 0, 0, 32'h0,       0, 32'h104,       5, 4});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 0, 1, 32'h200,     0, 32'h104,       6, 5});
        vecs.push_back('{32'h100,       0, 0, 32'h0,   0, 0, 0, 32'h0,       0, 32'h104,       6, 5});
        vecs.push_back('{32'h100,       1, 0, 32'h100, 0, 0, 1, 32'h200,     0, 32'h104,       7, 6});
        vecs.push_back('{32'h100,       0, 0, 32'h0,   0, 0, 0, 32'h0,       1, 32'h200,       7, 6});
        vecs.push_back('{32'hFFFF_FFFC, 0, 0, 32'h0,   0, 0, 0, 32'h0,       0, 32'h0,         7, 6});
        vecs.push_back('{32'h0000_1234, 1, 0, 32'h0000_1234, 13, 1, 1, 32'h8003, 0, 32'h1238,  8, 6});
        vecs.push_back('{32'h0000_1234, 1, 0, 32'h0000_1234, 13, 1, 1, 32'h8003, 1, 32'h8000,  9, 6});

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].v, vecs[i].st, vecs[i].epc, vecs[i].eidx,
                  vecs[i].pt, vecs[i].bt, vecs[i].etgt);
            #1;
            chk($sformatf("vec%0d_taken", i), 32'(if_pred_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_target", i), if_pred_target, vecs[i].exp_target);
            @(posedge clk);
            if (vecs[i].v && !vecs[i].st)
                model_train(32'(vecs[i].eidx), vecs[i].epc, vecs[i].pt, vecs[i].bt, vecs[i].etgt);
            #1;
            chk($sformatf("vec%0d_branches", i), perf_branches, vecs[i].exp_br);
            chk($sformatf("vec%0d_mispredicts", i), perf_mispredicts, vecs[i].exp_mp);
        end
`endif

        // Randomized traffic on a small PC pool so tags hit and alias often
        for (int n = 0; n < 600; n++) begin
            logic [31:0]   pc, epc, etgt;
            logic [IB-1:0] eidx;
            logic          v, st, bt, pt;
            bit            p_t;
            int unsigned   p_tg;
            pc   = (32'($urandom_range(0, 3)) << (IB + 2)) | (32'($urandom_range(0, 7)) << 2);
            epc  = (32'($urandom_range(0, 3)) << (IB + 2)) | (32'($urandom_range(0, 7)) << 2);
            v    = ($urandom_range(0, 9) < 7);
            st   = ($urandom_range(0, 9) < 2);
            bt   = $urandom_range(0, 1) == 1;
            etgt = $urandom;
            model_predict(epc, p_t, p_tg);
            pt   = ($urandom_range(0, 4) == 0) ? !p_t : p_t;
            eidx = ($urandom_range(0, 7) == 0) ? IB'($urandom) : IB'(model_index(epc));
            model_cycle(pc, v, st, epc, eidx, pt, bt, etgt);
        end

        // Asynchronous reset mid-cycle clears all state immediately
        model_cycle(32'h100, 1'b1, 1'b0, 32'h100, IB'(model_index(32'h100)), 1'b0, 1'b1, 32'h300);
        model_cycle(32'h100, 1'b1, 1'b0, 32'h100, IB'(model_index(32'h100)), 1'b0, 1'b1, 32'h300);
        @(negedge clk);
        drive(32'h100, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_taken", 32'(if_pred_taken), 32'd0);
        chk("async_rst_target", if_pred_target, 32'h104);
        chk("async_rst_branches", perf_branches, 32'd0);
        chk("async_rst_mispredicts", perf_mispredicts, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_cycle(32'h100, 1'b1, 1'b0, 32'h100, IB'(model_index(32'h100)), 1'b1, 1'b1, 32'h300);
        model_cycle(32'h100, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);

`ifdef BPU_GSHARE_EN
        // History T,T,N shifts into the low GHR bits and XORs into the lookup index
        model_cycle(32'h100, 1'b1, 1'b0, 32'h500, IB'(model_index(32'h500)), 1'b0, 1'b1, 32'h600);
        model_cycle(32'h100, 1'b1, 1'b0, 32'h500, IB'(model_index(32'h500)), 1'b0, 1'b1, 32'h600);
        model_cycle(32'h100, 1'b1, 1'b0, 32'h500, IB'(model_index(32'h500)), 1'b0, 1'b0, 32'h600);
        @(negedge clk);
        drive(32'h100, 1'b0, 1'b0, 32'h0, '0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("gshare_index", 32'(if_pred_index[2:0]), 32'h6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor feeding the IF stage and trained from EX-stage branch resolution. It is the producer of the predicted-taken bit and predicted target that travel down the pipeline to the hazard unit's mispredict compare. The update side consumes the same resolution signals that unit uses. It holds a direct-mapped branch target buffer (BTB) plus a table of 2-bit saturating counters (BHT), and keeps branch/mispredict performance counters.

## Interface
- INDEX_BITS, 6, log2 of BHT/BTB entries (64)
- TAG_BITS, 8, BTB tag width, taken from pc[INDEX_BITS+2 +: TAG_BITS]

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  32  PC being fetched
- if_pred_taken  out  1  prediction for if_pc
- if_pred_target  out  32  next-PC prediction: BTB target if taken, else if_pc+4
- if_pred_index  out  INDEX_BITS  table index used; carried down the pipeline with the instruction
- ex_valid  in  1  a conditional branch is resolved in EX this cycle
- ex_pc  in  32  PC of that branch
- ex_pred_index  in  INDEX_BITS  if_pred_index carried with that branch
- ex_pred_taken  in  1  prediction made for that branch
- ex_branch_taken  in  1  actual outcome
- ex_branch_target  in  32  actual taken target
- stall  in  1  pipeline frozen (driven from mem_stall_req); blocks all state updates
- perf_branches  out  32  resolved-branch count
- perf_mispredicts  out  32  mispredict count (direction mismatch only)

## Operation
- Storage: BHT[2^INDEX_BITS] × 2 bits; BTB[2^INDEX_BITS] × {valid, tag[TAG_BITS], target[30]}. Targets are word-aligned, so bits [1:0] are stored as 0.
- Index without the macro: if_pc[INDEX_BITS+1:2].
- Lookup is combinational from if_pc on registered tables. hit = valid && tag == if_pc tag field. if_pred_taken = hit && BHT[idx][1]. if_pred_target = if_pred_taken ? {target,2'b00} : if_pc+4. The +4 wraps modulo 2^32.
- Update occurs on a rising edge when ex_valid && !stall, at ex_pred_index:
  - BHT: taken → saturating increment (max 11); not taken → saturating decrement (min 00).
  - BTB: written {1, ex_pc tag, ex_branch_target[31:2]} only when taken; not-taken outcomes leave the BTB untouched.
  - perf_branches += 1. perf_mispredicts += 1 if ex_pred_taken != ex_branch_taken. Both counters saturate at 32'hFFFF_FFFF.
- stall high: no table, history, or counter change. Lookup outputs still track if_pc.
- Reset state: all BHT = 2'b01 (weakly not-taken), all BTB valid = 0, history = 0, both perf counters = 0.
- Outputs immediately after reset: if_pred_taken = 0, if_pred_target = if_pc+4, if_pred_index = index of if_pc.

## Timing
- Prediction: 0-cycle latency, combinational in the same cycle as if_pc.
- Update: visible to lookup on the cycle after the training edge.
- Same-index read and write in one cycle: the read returns the old value. There is no bypass.
- Reset assertion mid-operation: immediate asynchronous clear of all state. Release is synchronous to the next clk edge.
- No handshake: ex_valid is a single-cycle qualifier, one update per cycle maximum.

## Configuration
- BPU_GSHARE_EN defined:
  - An INDEX_BITS global history register (GHR) is added.
  - Index = if_pc[INDEX_BITS+1:2] ^ GHR.
  - GHR updates non-speculatively on each training edge: GHR <= {GHR[INDEX_BITS-2:0], ex_branch_taken}.
  - The BTB tag and lookup rules are unchanged.
- Undefined: there is no GHR, and the index is the PC bits only. Training always uses ex_pred_index in both builds.

## Test plan
- Reset, then if_pc=0x0000_0040 → if_pred_taken=0, if_pred_target=0x0000_0044; both perf counters are 0.
- Train pc 0x100 taken to 0x200 twice (ex_valid pulses, ex_pred_taken=0) → BHT 01→10→11, lookup 0x100 gives taken/0x200, perf_branches=2, perf_mispredicts=2.
- From counter 11, train not-taken three times → counter ends at 00 and does not wrap. Lookup is not-taken/0x104, and the BTB entry remains valid.
- Aliasing: pc 0x100 trained taken, then lookup pc 0x100+(1<<(INDEX_BITS+2)) → tag miss, not taken.
- stall=1 while ex_valid=1 → tables and perf counters are unchanged. Deassert stall with ex_valid=1 → exactly one update.
- BPU_GSHARE_EN build, after outcomes T,T,N → GHR=3'b110 (low bits); lookup index for pc 0x100 = 0x00^0x06 = 6 with INDEX_BITS=6.
